// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO that sits in front of a UART transmitter. Bytes are written on the
// write side and handed to the transmitter one at a time. A small read-side
// FSM waits for the transmitter to report busy and then idle before it issues
// the next byte, so no more than one byte is ever in flight.
//
// Parameters:
//   p_DATA_BITS   byte width (must match the transmitter)
//   p_DEPTH_LOG2  log2 of the FIFO depth (>= 1)
//
// Ports:
//   i_clk         single clock, all state on its rising edge
//   i_reset       asynchronous active-high reset
//   iv_wr_data    byte to enqueue
//   i_wr          write strobe, one byte per high cycle
//   o_full        FIFO holds 2^p_DEPTH_LOG2 bytes (combinational)
//   o_empty       FIFO holds no bytes (combinational)
//   o_overflow    one-cycle pulse after a write was dropped because the FIFO was full
//   ov_data       byte presented to the transmitter; holds until the next pop
//   o_data_ready  one-cycle strobe to the transmitter
//   i_tx_busy     busy flag from the transmitter
//   ov_level      occupancy (write pointer minus read pointer); only present
//                 when the macro UART_TX_FIFO_LEVEL_EN is defined
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int p_DATA_BITS  = 8,
    parameter int p_DEPTH_LOG2 = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [p_DATA_BITS-1:0] iv_wr_data,
    input  logic                   i_wr,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_overflow,
    output logic [p_DATA_BITS-1:0] ov_data,
    output logic                   o_data_ready,
    input  logic                   i_tx_busy
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [p_DEPTH_LOG2:0]  ov_level
`endif
);

    localparam int DEPTH = 1 << p_DEPTH_LOG2;

    // Pointer increment constant, sized to the pointer width.
    localparam logic [p_DEPTH_LOG2:0] PTR_ONE_C = {{p_DEPTH_LOG2{1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_ISSUE     = 2'b01;
    localparam logic [1:0] ST_WAIT_BUSY = 2'b10;
    localparam logic [1:0] ST_WAIT_DONE = 2'b11;

    logic [p_DATA_BITS-1:0]  mem_r [0:DEPTH-1];
    logic [p_DEPTH_LOG2:0]   wr_ptr_r;
    logic [p_DEPTH_LOG2:0]   rd_ptr_r;
    logic [1:0]              state_r;
    logic [1:0]              state_s;
    logic [p_DATA_BITS-1:0]  data_r;
    logic                    data_ready_r;
    logic                    overflow_r;
    logic                    empty_s;
    logic                    full_s;
    logic                    wr_en_s;
    logic                    wr_drop_s;
    logic                    pop_s;

    // Occupancy flags and the write/pop qualifiers, all derived from the pointers.
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        // Full: same slot index, but the write pointer is one lap ahead.
        full_s    = (wr_ptr_r[p_DEPTH_LOG2-1:0] == rd_ptr_r[p_DEPTH_LOG2-1:0]) &&
                    (wr_ptr_r[p_DEPTH_LOG2] != rd_ptr_r[p_DEPTH_LOG2]);
        wr_en_s   = i_wr && !full_s;
        // A pop in the same cycle does not rescue a write made while full.
        wr_drop_s = i_wr && full_s;
        pop_s     = (state_r == ST_IDLE) && !empty_s && !i_tx_busy;
    end

    // Read-side FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_s = ST_WAIT_DONE;
                end else begin
                    state_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Pointers, FSM state and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_r     <= {(p_DEPTH_LOG2+1){1'b0}};
            rd_ptr_r     <= {(p_DEPTH_LOG2+1){1'b0}};
            state_r      <= ST_IDLE;
            data_r       <= {p_DATA_BITS{1'b0}};
            data_ready_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                data_r   <= mem_r[rd_ptr_r[p_DEPTH_LOG2-1:0]];
            end
            state_r      <= state_s;
            // Registered decode of the next state: high exactly while in ISSUE.
            data_ready_r <= (state_s == ST_ISSUE);
            overflow_r   <= wr_drop_s;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[p_DEPTH_LOG2-1:0]] <= iv_wr_data;
        end
    end

    assign o_empty      = empty_s;
    assign o_full       = full_s;
    assign o_overflow   = overflow_r;
    assign ov_data      = data_r;
    assign o_data_ready = data_ready_r;

`ifdef UART_TX_FIFO_LEVEL_EN
    // Pointer difference wraps correctly because the pointers carry a lap bit.
    assign ov_level = wr_ptr_r - rd_ptr_r;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. The transmitter busy input is either
// driven by hand or by a simple transmitter model that stays busy for
// tx_len cycles after each o_data_ready strobe. Every strobe is logged
// with its byte, cycle number and the busy level seen at that moment.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    logic       i_clk;
    logic       i_reset;
    logic [7:0] iv_wr_data;
    logic       i_wr;
    logic       o_full;
    logic       o_empty;
    logic       o_overflow;
    logic [7:0] ov_data;
    logic       o_data_ready;
    logic       i_tx_busy;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] ov_level;
`endif

    uart_tx_fifo #(
        .p_DATA_BITS  (8),
        .p_DEPTH_LOG2 (4)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .iv_wr_data   (iv_wr_data),
        .i_wr         (i_wr),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_overflow   (o_overflow),
        .ov_data      (ov_data),
        .o_data_ready (o_data_ready),
        .i_tx_busy    (i_tx_busy)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .ov_level     (ov_level)
`endif
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Transmitter model / manual busy selection
    logic model_mode = 1'b0;
    logic man_busy   = 1'b0;
    int   tx_len     = 10;
    int   tx_cnt     = 0;

    assign i_tx_busy = model_mode ? (tx_cnt != 0) : man_busy;

    // Strobe log and overflow counter
    logic [7:0] log_data [$];
    int         log_cyc  [$];
    logic       log_busy [$];
    int         cyc      = 0;
    int         ovf_cnt  = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Transmitter model: busy for tx_len cycles after each strobe.
    always @(posedge i_clk) begin
        if (o_data_ready) begin
            tx_cnt <= tx_len;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end
    end

    // Log every strobe and count overflow pulses.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_data_ready) begin
            log_data.push_back(ov_data);
            log_cyc.push_back(cyc);
            log_busy.push_back(i_tx_busy);
        end
        if (o_overflow) begin
            ovf_cnt <= ovf_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(negedge i_clk);
    endtask

    // Wait (bounded) until n strobes have been logged in total.
    task automatic wait_pulses(input string tag, input int n, input int budget);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        chk(tag, 32'(log_data.size()), 32'(n));
    endtask

    initial begin
        int base;
        int ovf_base;
        int idx;
        int guard;

        i_reset    = 1'b1;
        i_wr       = 1'b0;
        iv_wr_data = 8'h00;

        // ---- reset state ----
        cycle();
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_dready", 32'(o_data_ready), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_data", 32'(ov_data), 32'h00);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("rst_level", 32'(ov_level), 32'd0);
`endif
        cycle();

        // ---- single byte latency; write on the first edge after release ----
        i_reset    = 1'b0;
        i_wr       = 1'b1;
        iv_wr_data = 8'hA5;
        cycle();
        i_wr = 1'b0;
        chk("lat_n1_dready", 32'(o_data_ready), 32'd0);
        chk("lat_n1_empty", 32'(o_empty), 32'd0);
        cycle();
        chk("lat_n2_dready", 32'(o_data_ready), 32'd1);
        chk("lat_n2_data", 32'(ov_data), 32'hA5);
        chk("lat_n2_empty", 32'(o_empty), 32'd1);
        cycle();
        chk("lat_n3_dready", 32'(o_data_ready), 32'd0);
        chk("lat_n3_data", 32'(ov_data), 32'hA5);

        // ---- busy never rises: FSM must hold in WAIT_BUSY ----
        i_wr       = 1'b1;
        iv_wr_data = 8'h5A;
        cycle();
        i_wr = 1'b0;
        repeat (8) cycle();
        chk("stall_pulses", 32'(log_data.size()), 32'd1);
        chk("stall_empty", 32'(o_empty), 32'd0);
        chk("stall_hold", 32'(ov_data), 32'hA5);
        man_busy = 1'b1;
        cycle();
        man_busy = 1'b0;
        wait_pulses("stall_release", 2, 10);
        chk("stall_data", 32'(log_data[1]), 32'h5A);
        cycle();

        // ---- reset with busy high; FSM restarts in IDLE ----
        man_busy = 1'b1;
        i_reset  = 1'b1;
        cycle();
        chk("rst2_dready", 32'(o_data_ready), 32'd0);
        chk("rst2_empty", 32'(o_empty), 32'd1);
        i_reset = 1'b0;

        // ---- fill to full while the transmitter is busy, then overflow ----
        ovf_base = ovf_cnt;
        for (int i = 0; i < 16; i++) begin
            i_wr       = 1'b1;
            iv_wr_data = 8'(i);
            cycle();
        end
        i_wr = 1'b0;
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_empty", 32'(o_empty), 32'd0);
        chk("fill_no_ovf", 32'(ovf_cnt - ovf_base), 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("fill_level", 32'(ov_level), 32'd16);
`endif
        i_wr       = 1'b1;
        iv_wr_data = 8'hFF;
        cycle();
        i_wr = 1'b0;
        chk("ovf_pulse", 32'(o_overflow), 32'd1);
        chk("ovf_full", 32'(o_full), 32'd1);
        cycle();
        chk("ovf_one_cycle", 32'(o_overflow), 32'd0);
        chk("ovf_count", 32'(ovf_cnt - ovf_base), 32'd1);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("ovf_level", 32'(ov_level), 32'd16);
`endif

        // ---- drain through the transmitter model ----
        base       = log_data.size();
        tx_len     = 10;
        model_mode = 1'b1;
        wait_pulses("drain_count", base + 16, 400);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("drain_byte%0d", j), 32'(log_data[base + j]), 32'(j));
        end
        repeat (20) cycle();
        chk("drain_no_ff", 32'(log_data.size()), 32'(base + 16));
        chk("drain_empty", 32'(o_empty), 32'd1);

        // ---- three bytes through a 10-cycle transmitter ----
        base = log_data.size();
        i_wr = 1'b1;
        iv_wr_data = 8'h11;
        cycle();
        iv_wr_data = 8'h22;
        cycle();
        iv_wr_data = 8'h33;
        cycle();
        i_wr = 1'b0;
        wait_pulses("tx3_count", base + 3, 100);
        chk("tx3_b0", 32'(log_data[base]), 32'h11);
        chk("tx3_b1", 32'(log_data[base + 1]), 32'h22);
        chk("tx3_b2", 32'(log_data[base + 2]), 32'h33);
        chk("tx3_busy0", 32'(log_busy[base]), 32'd0);
        chk("tx3_busy1", 32'(log_busy[base + 1]), 32'd0);
        chk("tx3_busy2", 32'(log_busy[base + 2]), 32'd0);
        // 10 busy cycles + WAIT_BUSY exit + WAIT_DONE exit + IDLE pop
        chk("tx3_gap1", 32'(log_cyc[base + 1] - log_cyc[base]), 32'd13);
        chk("tx3_gap2", 32'(log_cyc[base + 2] - log_cyc[base + 1]), 32'd13);
        repeat (20) cycle();
        chk("tx3_no_extra", 32'(log_data.size()), 32'(base + 3));

        // ---- asynchronous reset mid-byte with 5 bytes queued ----
        base = log_data.size();
        for (int i = 0; i < 6; i++) begin
            i_wr       = 1'b1;
            iv_wr_data = 8'(8'h41 + i);
            cycle();
        end
        i_wr = 1'b0;
        wait_pulses("mid_first", base + 1, 20);
        repeat (3) cycle();
        chk("mid_queued", 32'(o_empty), 32'd0);
        #2;
        i_reset = 1'b1;
        #1;
        chk("async_empty", 32'(o_empty), 32'd1);
        chk("async_full", 32'(o_full), 32'd0);
        chk("async_dready", 32'(o_data_ready), 32'd0);
        chk("async_ovf", 32'(o_overflow), 32'd0);
        chk("async_data", 32'(ov_data), 32'h00);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("async_level", 32'(ov_level), 32'd0);
`endif
        cycle();
        i_reset = 1'b0;
        repeat (40) cycle();
        chk("post_rst_silent", 32'(log_data.size()), 32'(base + 1));
        chk("post_rst_empty", 32'(o_empty), 32'd1);
        i_wr       = 1'b1;
        iv_wr_data = 8'h77;
        cycle();
        i_wr = 1'b0;
        wait_pulses("post_rst_new", base + 2, 30);
        chk("post_rst_data", 32'(log_data[base + 1]), 32'h77);
        repeat (20) cycle();

        // ---- three wrap-around passes with concurrent writes and pops ----
        base     = log_data.size();
        ovf_base = ovf_cnt;
        tx_len   = 1;
        idx      = 0;
        guard    = 0;
        while (idx < 48 && guard < 1000) begin
            if (!o_full) begin
                i_wr       = 1'b1;
                iv_wr_data = 8'(idx % 16);
                idx++;
            end else begin
                i_wr = 1'b0;
            end
            cycle();
            guard++;
        end
        i_wr = 1'b0;
        chk("wrap_written", 32'(idx), 32'd48);
        wait_pulses("wrap_count", base + 48, 600);
        for (int j = 0; j < 48; j++) begin
            chk($sformatf("wrap_byte%0d", j), 32'(log_data[base + j]), 32'(j % 16));
        end
        chk("wrap_no_ovf", 32'(ovf_cnt - ovf_base), 32'd0);
        chk("wrap_empty", 32'(o_empty), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 p_DATA_BITS, 8, byte width; SHALL match the transmitter's p_DATA_BITS.
REQ-002 p_DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 by default); SHALL be >= 1.
REQ-003 i_clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 iv_wr_data  input  p_DATA_BITS  byte to enqueue.
REQ-006 i_wr  input  1  write strobe; one byte is enqueued per high cycle.
REQ-007 o_full  output  1  FIFO holds 2^p_DEPTH_LOG2 bytes.
REQ-008 o_empty  output  1  FIFO holds 0 bytes.
REQ-009 o_overflow  output  1  one-cycle pulse: a write was dropped.
REQ-010 ov_data  output  p_DATA_BITS  byte presented to the transmitter's iv_data.
REQ-011 o_data_ready  output  1  one-cycle pulse to the transmitter's i_data_ready.
REQ-012 i_tx_busy  input  1  the transmitter's o_busy.

Function
REQ-013 Storage SHALL be a circular buffer of 2^p_DEPTH_LOG2 entries.
REQ-014 Read and write pointers SHALL be p_DEPTH_LOG2+1 bits wide and wrap modulo 2^(p_DEPTH_LOG2+1).
REQ-015 o_empty SHALL be high when the pointers are equal.
REQ-016 o_full SHALL be high when the pointers' low bits are equal and their MSBs differ; both flags are combinational from the pointers.
REQ-017 Write path: i_wr=1 and o_full=0 SHALL store iv_wr_data at the write pointer and increment it at that edge.
REQ-018 Write path: i_wr=1 and o_full=1 SHALL drop the byte, leave the pointers unchanged and assert o_overflow for the next cycle only, even if a pop occurs in the same cycle.
REQ-019 A write and a pop in the same cycle SHALL both take effect (occupancy unchanged).
REQ-020 The read side SHALL be an FSM with four states: IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE: if o_empty=0 and i_tx_busy=0, ov_data SHALL load the entry at the read pointer, the read pointer SHALL increment and the FSM SHALL go to ISSUE; otherwise the FSM SHALL stay in IDLE.
REQ-022 ISSUE: o_data_ready SHALL be high for exactly this one cycle, then the FSM SHALL go to WAIT_BUSY.
REQ-023 WAIT_BUSY: the FSM SHALL stay until i_tx_busy=1, then go to WAIT_DONE.
REQ-024 WAIT_DONE: the FSM SHALL stay until i_tx_busy=0, then go to IDLE.
REQ-025 o_data_ready SHALL be high only in ISSUE; at most one byte SHALL be in flight to the transmitter.
REQ-026 ov_data SHALL hold the last popped byte until the next pop.
REQ-027 Latency: a write to an empty FIFO with the transmitter idle in cycle N SHALL produce o_data_ready high in cycle N+2.
REQ-028 Back-to-back bytes SHALL be issued no sooner than the cycle after i_tx_busy falls, plus one IDLE cycle.

Reset
REQ-029 i_reset=1 SHALL immediately, without a clock edge, force pointers=0, FSM=IDLE, ov_data=0, o_data_ready=0 and o_overflow=0.
REQ-030 During reset, o_empty SHALL be 1 and o_full SHALL be 0; memory contents need not be cleared.
REQ-031 Reset mid-transfer SHALL discard all queued bytes.
REQ-032 After reset, the FSM SHALL restart in IDLE regardless of i_tx_busy.
REQ-033 Writes SHALL be accepted from the first clock edge after i_reset falls.

Configuration
REQ-034 Macro UART_TX_FIFO_LEVEL_EN.
REQ-035 When UART_TX_FIFO_LEVEL_EN is defined, the block SHALL add output ov_level (width p_DEPTH_LOG2+1).
REQ-036 ov_level SHALL equal write pointer minus read pointer (0..2^p_DEPTH_LOG2) and reset to 0.
REQ-037 When UART_TX_FIFO_LEVEL_EN is undefined, the ov_level port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-038 After reset, write 0xA5 with i_tx_busy=0 -> o_data_ready pulses 2 cycles later with ov_data=0xA5; o_empty returns to 1.
REQ-039 Write 16 bytes 0x00..0x0F with i_tx_busy held 1 -> o_full=1, level=16; a 17th write (0xFF) -> o_overflow pulses once, 0xFF never emitted.
REQ-040 Model a transmitter that busies 10 cycles per byte; queue 0x11,0x22,0x33 -> exactly three o_data_ready pulses, in order, each only after i_tx_busy has fallen.
REQ-041 Hold i_tx_busy=0 permanently after ISSUE -> the FSM stays in WAIT_BUSY and no further pulse occurs until i_tx_busy toggles 1 then 0.
REQ-042 Assert i_reset mid-byte with 5 bytes queued -> outputs clear asynchronously, o_empty=1, and no byte is emitted after release until a new write.
REQ-043 Write the 0x00..0x0F fill for 3 full passes (wrap-around) with simultaneous writes and pops -> output order matches input order and no overflow occurs.
